// File: rtl/s2p_receiver.sv
// s2p_receiver: SPI mode-0 serial-to-parallel receiver with valid/ready output register.
// Frames are FL bits MSB first; the low WL bits are delivered with a sign-extension check.
module s2p_receiver #(
  parameter int WL   = 13,
  parameter int FL   = 16,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          iRST,
  input  logic          en,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          sdi,
  input  logic          out_ready,
  output logic [WL-1:0] out_data,
  output logic          out_sign_err,
  output logic          out_valid,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy
);
  localparam int CW = $clog2(FL + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;
  state_t          r_state, w_next;
  logic [SYNC-1:0] r_sclk_s, r_cs_s, r_sdi_s, r_fill;
  logic            r_sclk_d, r_cs_d, r_arm;
  logic [CW-1:0]   r_cnt;
  logic [FL-1:0]   r_shift, w_frame;
  logic            w_sclk_rise, w_cs_fall, w_cs_rise, w_sdi, w_done, w_ferr, w_shift;
  logic [FL-WL:0]  w_top;
  always_ff @(posedge clk or posedge iRST)
    if (iRST) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_sdi_s  <= '0;
      r_fill   <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
      r_arm    <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC-2:0], sclk};
      r_cs_s   <= {r_cs_s[SYNC-2:0], cs_n};
      r_sdi_s  <= {r_sdi_s[SYNC-2:0], sdi};
      r_fill   <= {r_fill[SYNC-2:0], 1'b1};
      r_sclk_d <= r_sclk_s[SYNC-1];
      r_cs_d   <= r_cs_s[SYNC-1];
      r_arm    <= r_arm | (r_fill[SYNC-1] & r_cs_s[SYNC-1]);
    end
  // cs_n falls count only once it has been seen high after reset, so a held-low cs_n is ignored
  assign w_sclk_rise = r_sclk_s[SYNC-1] & ~r_sclk_d;
  assign w_cs_fall   = r_arm & r_cs_d & ~r_cs_s[SYNC-1];
  assign w_cs_rise   = r_cs_s[SYNC-1] & ~r_cs_d;
  assign w_sdi       = r_sdi_s[SYNC-1];
  assign w_frame     = {r_shift[FL-2:0], w_sdi};
  assign w_top       = w_frame[FL-1:WL-1];
  always_comb begin
    w_next  = r_state;
    w_done  = 1'b0;
    w_ferr  = 1'b0;
    w_shift = 1'b0;
    unique case (r_state)
      IDLE:    w_next = (w_cs_fall & en) ? SHIFT : IDLE;
      SHIFT:
        if (!en) w_next = IDLE;
        else if (w_cs_rise) begin
          w_next = IDLE;
          w_ferr = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          w_done  = (r_cnt == CW'(FL - 1));
          w_next  = w_done ? WAIT_CS : SHIFT;
        end
      WAIT_CS: w_next = (!en || w_cs_rise) ? IDLE : WAIT_CS;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge iRST)
    if (iRST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      out_data     <= '0;
      out_sign_err <= 1'b0;
      out_valid    <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next == IDLE) ? '0 : r_cnt + CW'(w_shift);
      r_shift   <= w_shift ? w_frame : r_shift;
      frame_err <= w_ferr;
      overrun   <= w_done & out_valid & ~out_ready;
      if (w_done && (!out_valid || out_ready)) begin
        out_data     <= w_frame[WL-1:0];
        out_sign_err <= ~((&w_top) | ~(|w_top));
        out_valid    <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_s2p_receiver.sv
// tb_s2p_receiver: directed bench for s2p_receiver driving SPI frames bit by bit.
// A negedge monitor records delivered words and error pulses for the scenario tasks.
module tb_s2p_receiver;
  localparam int WL = 13, FL = 16, SYNC = 2;
  logic clk = 0, iRST = 1, en = 1, sclk = 0, cs_n = 1, sdi = 0, out_ready = 1;
  logic [WL-1:0] out_data;
  logic out_sign_err, out_valid, frame_err, overrun, busy;
  logic [WL:0] q[$];
  int n_ferr = 0, n_ovr = 0, n_chk = 0, n_err = 0;

  s2p_receiver #(.WL(WL), .FL(FL), .SYNC(SYNC)) dut (
    .clk(clk), .iRST(iRST), .en(en), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
    .out_ready(out_ready), .out_data(out_data), .out_sign_err(out_sign_err),
    .out_valid(out_valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_sign_err, out_data});
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) sdi = b;
    wait_n(2);
    sclk = 1;
    wait_n(4);
    sclk = 0;
    wait_n(2);
  endtask

  task automatic cs_lo;
    @(negedge clk) cs_n = 0;
    wait_n(4);
  endtask

  task automatic cs_hi;
    @(negedge clk) cs_n = 1;
    wait_n(6);
  endtask

  task automatic frame(input logic [15:0] d);
    cs_lo();
    for (int i = 15; i >= 0; i--) send_bit(d[i]);
    cs_hi();
  endtask

  task automatic clear_mon;
    q.delete();
    n_ferr = 0;
    n_ovr = 0;
  endtask

  task automatic test_reset;
    wait_n(3);
    n_chk++; if ({out_valid, out_data, out_sign_err, frame_err, overrun, busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h req 0", {out_valid, out_data, out_sign_err, frame_err, overrun, busy});
    end
    @(negedge clk) iRST = 0;
    wait_n(4);
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release busy=%b valid=%b req 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single;
    logic [15:0] d = 16'hFFFB;
    clear_mon();
    out_ready = 1;
    cs_lo();
    for (int i = 15; i >= 1; i--) send_bit(d[i]);
    n_chk++; if (busy !== 1'b1) begin
      n_err++; $display("FAIL single_busy got %b req 1", busy);
    end
    @(negedge clk) sdi = d[0];
    wait_n(2);
    sclk = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_chk++; if (out_valid !== (i == 3)) begin
        n_err++; $display("FAIL single_valid_cycle%0d got %b req %b", i, out_valid, i == 3);
      end
      if (i == 3) begin
        n_chk++; if (out_data !== 13'h1FFB || out_sign_err !== 1'b0) begin
          n_err++; $display("FAIL single_data got %h/%b req 1ffb/0", out_data, out_sign_err);
        end
      end
    end
    sclk = 0;
    wait_n(2);
    cs_hi();
    n_chk++; if (q.size() !== 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_count got %0d busy %b req 1 0", q.size(), busy);
    end
  endtask

  task automatic test_back_to_back;
    clear_mon();
    frame(16'h0ABC);
    frame(16'h4000);
    n_chk++; if (q.size() !== 2) begin
      n_err++; $display("FAIL b2b_count got %0d req 2", q.size());
    end else begin
      n_chk++; if (q[0] !== {1'b0, 13'h0ABC}) begin
        n_err++; $display("FAIL b2b_first got %h req %h", q[0], {1'b0, 13'h0ABC});
      end
      n_chk++; if (q[1] !== {1'b1, 13'h0000}) begin
        n_err++; $display("FAIL b2b_second got %h req %h", q[1], {1'b1, 13'h0000});
      end
    end
  endtask

  task automatic test_short_frame;
    clear_mon();
    cs_lo();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    cs_hi();
    n_chk++; if (n_ferr !== 1 || q.size() !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL short_frame ferr=%0d words=%0d busy=%b req 1 0 0", n_ferr, q.size(), busy);
    end
    frame(16'h1234);
    n_chk++; if (q.size() !== 1 || q[0][WL-1:0] !== 13'h1234 || n_ferr !== 1) begin
      n_err++; $display("FAIL short_recover words=%0d data=%h ferr=%0d req 1 1234 1", q.size(), out_data, n_ferr);
    end
  endtask

  task automatic test_overrun;
    clear_mon();
    out_ready = 0;
    frame(16'h0001);
    frame(16'h0002);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 13'h0001) begin
      n_err++; $display("FAIL overrun_hold valid=%b data=%h req 1 0001", out_valid, out_data);
    end
    n_chk++; if (n_ovr !== 1) begin
      n_err++; $display("FAIL overrun_pulses got %0d req 1", n_ovr);
    end
    @(negedge clk) out_ready = 1;
    wait_n(4);
    n_chk++; if (q.size() !== 1 || q[0][WL-1:0] !== 13'h0001 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL overrun_drain words=%0d valid=%b req 1 0", q.size(), out_valid);
    end
  endtask

  task automatic test_long_frame;
    logic [19:0] d = {16'h0155, 4'hF};
    clear_mon();
    cs_lo();
    for (int i = 19; i >= 0; i--) send_bit(d[i]);
    cs_hi();
    n_chk++; if (q.size() !== 1 || q[0] !== {1'b0, 13'h0155}) begin
      n_err++; $display("FAIL long_frame words=%0d first=%h req 1 0155", q.size(), q.size() ? q[0] : '0);
    end
  endtask

  task automatic test_reset_mid;
    clear_mon();
    out_ready = 0;
    frame(16'h0ABC);
    cs_lo();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    @(negedge clk) iRST = 1;
    #1;
    n_chk++; if ({out_valid, out_data, out_sign_err, frame_err, overrun, busy} !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs got %h req 0", {out_valid, out_data, out_sign_err, frame_err, overrun, busy});
    end
    wait_n(2);
    iRST = 0;
    out_ready = 1;
    clear_mon();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    wait_n(4);
    n_chk++; if (q.size() !== 0 || busy !== 1'b0 || n_ferr !== 0) begin
      n_err++; $display("FAIL reset_mid_ignored words=%0d busy=%b ferr=%0d req 0 0 0", q.size(), busy, n_ferr);
    end
    cs_hi();
    frame(16'h0007);
    n_chk++; if (q.size() !== 1 || q[0] !== {1'b0, 13'h0007}) begin
      n_err++; $display("FAIL reset_mid_next words=%0d data=%h req 1 0007", q.size(), out_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_long_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
